// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: AXI-stream in, first-word-fall-through AXI-stream out,
// plus a saturating counter of receiver overflow pulses.
module uart_rx_fifo #(
  parameter int depth_log2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [7:0]            s_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [7:0]            m_tdata,
  output logic [depth_log2:0]   level,
  input  logic                  rx_overflow,
  input  logic                  clear_count,
  output logic [7:0]            overflow_count
);

  localparam int depth = 1 << depth_log2;
  localparam logic [depth_log2:0] full_level = {1'b1, {depth_log2{1'b0}}};

  // Handshake: a byte moves on a side only at a posedge where both valid and ready are high.
  // s_tready and m_tvalid derive from registered pointers only, so the two sides never
  // depend combinationally on each other.

  logic [7:0]            mem [depth];
  logic [depth_log2:0]   wr_ptr;
  logic [depth_log2:0]   rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (level == '0);
  assign full     = (level == full_level);
  assign s_tready = !full;
  assign m_tvalid = !empty;
  assign m_tdata  = mem[rd_ptr[depth_log2-1:0]];
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;

  // Storage is cleared on reset so m_tdata reads zero while the FIFO is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < depth; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (push) begin
      mem[wr_ptr[depth_log2-1:0]] <= s_tdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A clear coinciding with an overflow pulse keeps that pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_count <= 8'h00;
    end else if (clear_count) begin
      overflow_count <= rx_overflow ? 8'h01 : 8'h00;
    end else if (rx_overflow && (overflow_count != 8'hFF)) begin
      overflow_count <= overflow_count + 8'h01;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: bytes queued on push, compared on pop,
// occupancy and flags checked against the queue size every cycle.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic       s_tvalid;
  logic       s_tready;
  logic [7:0] s_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic [7:0] m_tdata;
  logic [4:0] level;
  logic       rx_overflow;
  logic       clear_count;
  logic [7:0] overflow_count;

  logic [7:0] exp_q[$];
  int         checks;
  int         errors;
  bit         last_push;
  bit         last_pop;

  uart_rx_fifo #(.depth_log2(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_tvalid       (s_tvalid),
    .s_tready       (s_tready),
    .s_tdata        (s_tdata),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready),
    .m_tdata        (m_tdata),
    .level          (level),
    .rx_overflow    (rx_overflow),
    .clear_count    (clear_count),
    .overflow_count (overflow_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, called and returning at negedge. Handshakes are decided from the
  // values present before the edge; the queue model is then compared with the DUT.
  task automatic step();
    bit         push;
    bit         pop;
    logic [7:0] d;
    push = s_tvalid && s_tready;
    pop  = m_tvalid && m_tready;
    d    = m_tdata;
    if (pop) begin
      if (exp_q.size() == 0) check("pop_when_empty", 1, 0);
      else                   check("data", {24'h0, d}, {24'h0, exp_q.pop_front()});
    end
    if (push) exp_q.push_back(s_tdata);
    last_push = push;
    last_pop  = pop;
    @(posedge clk);
    @(negedge clk);
    check("level", {27'h0, level}, exp_q.size());
    check("m_tvalid", {31'h0, m_tvalid}, {31'h0, exp_q.size() != 0});
    check("s_tready", {31'h0, s_tready}, {31'h0, exp_q.size() < 16});
    if (exp_q.size() != 0) check("head", {24'h0, m_tdata}, {24'h0, exp_q[0]});
  endtask

  task automatic push_bytes(input int n, input logic [7:0] base);
    m_tready = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = base + i[7:0];
      step();
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    while (exp_q.size() != 0 && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) check("drain_timeout", 1, 0);
    m_tready = 1'b0;
  endtask

  initial begin
    int pops_before;
    int sent;
    int guard;
    int max_level;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    s_tvalid    = 1'b0;
    s_tdata     = 8'h00;
    m_tready    = 1'b0;
    rx_overflow = 1'b0;
    clear_count = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_m_tvalid", {31'h0, m_tvalid}, 0);
    check("rst_level", {27'h0, level}, 0);
    check("rst_s_tready", {31'h0, s_tready}, 1);
    check("rst_m_tdata", {24'h0, m_tdata}, 0);
    check("rst_ovf", {24'h0, overflow_count}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single byte
    s_tvalid = 1'b1;
    s_tdata  = 8'hA5;
    step();
    s_tvalid = 1'b0;
    check("single_data", {24'h0, m_tdata}, 32'hA5);
    check("single_level", {27'h0, level}, 1);
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    check("single_empty", {31'h0, m_tvalid}, 0);

    // fill and stall
    push_bytes(16, 8'h00);
    check("full_level", {27'h0, level}, 16);
    check("full_ready", {31'h0, s_tready}, 0);
    s_tvalid = 1'b1;
    s_tdata  = 8'h10;
    repeat (5) step();
    check("stall_level", {27'h0, level}, 16);
    m_tready    = 1'b1;
    pops_before = 0;
    guard       = 0;
    while (s_tvalid && guard < 50) begin
      step();
      if (last_push) s_tvalid = 1'b0;
      else if (last_pop) pops_before++;
      guard++;
    end
    check("accept_after_pop", pops_before, 1);
    drain();

    // push+pop at full: pop only
    push_bytes(16, 8'h40);
    s_tvalid = 1'b1;
    s_tdata  = 8'hEE;
    m_tready = 1'b1;
    step();
    s_tvalid = 1'b0;
    check("pp_full_level", {27'h0, level}, 15);
    drain();

    // push+pop at empty: push only
    s_tvalid = 1'b1;
    s_tdata  = 8'h5A;
    m_tready = 1'b1;
    step();
    s_tvalid = 1'b0;
    check("pp_empty_level", {27'h0, level}, 1);
    drain();

    // steady push+pop at level 5
    push_bytes(5, 8'h80);
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_tdata = 8'($urandom_range(0, 255));
      step();
    end
    s_tvalid = 1'b0;
    check("steady_level", {27'h0, level}, 5);
    drain();

    // random back-pressure
    sent      = 0;
    guard     = 0;
    max_level = 0;
    s_tvalid  = 1'b0;
    while ((sent < 1000 || exp_q.size() != 0) && guard < 20000) begin
      if (!s_tvalid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        s_tvalid = 1'b1;
        s_tdata  = 8'($urandom_range(0, 255));
      end
      m_tready = ($urandom_range(0, 2) != 0);
      step();
      if (int'(level) > max_level) max_level = int'(level);
      if (last_push) begin
        sent++;
        s_tvalid = 1'b0;
      end
      guard++;
    end
    check("random_done", {31'h0, guard < 20000}, 1);
    check("random_max_level", {31'h0, max_level <= 16}, 1);
    m_tready = 1'b0;

    // overflow counter
    rx_overflow = 1'b1;
    repeat (10) step();
    check("ovf_10", {24'h0, overflow_count}, 10);
    repeat (290) step();
    check("ovf_sat", {24'h0, overflow_count}, 255);
    clear_count = 1'b1;
    step();
    check("ovf_clear_pulse", {24'h0, overflow_count}, 1);
    rx_overflow = 1'b0;
    step();
    check("ovf_clear", {24'h0, overflow_count}, 0);
    clear_count = 1'b0;

    // reset mid-operation, asserted between edges
    push_bytes(7, 8'h20);
    check("pre_rst_level", {27'h0, level}, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_tvalid", {31'h0, m_tvalid}, 0);
    check("mid_rst_level", {27'h0, level}, 0);
    check("mid_rst_s_tready", {31'h0, s_tready}, 1);
    check("mid_rst_m_tdata", {24'h0, m_tdata}, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b1;
    s_tdata  = 8'h3C;
    step();
    s_tdata  = 8'h77;
    step();
    s_tvalid = 1'b0;
    check("post_rst_head", {24'h0, m_tdata}, 32'h3C);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
